// File: rtl/display_pkg.sv
// display_pkg: shared codes, state type and producer packet type for the display mux.
package display_pkg;
  localparam logic [3:0] BCD_DASH = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hB;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  typedef enum logic {IDLE, SHOW} state_t;
  typedef logic [5:0][3:0] bcdPac_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD to active-low 7-segment pattern, segment a = LSB.
module seg7_decode import display_pkg::*; (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      BCD_DASH: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_mux.sv
// display_mux: multi-source 7-segment controller with idle timeout.
// Optional per-digit blinking is built when DISPLAY_BLINK_EN is defined.
module display_mux import display_pkg::*; #(
  parameter int N_SRC = 2,
  parameter int N_DIG = 6,
  parameter int TIMEOUT_CYC = 0,
  parameter int BLINK_DIV = 25_000_000,
  localparam int AW = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_en,
  input  logic [N_SRC*N_DIG*4-1:0] src_bcd,
  input  logic [N_SRC*N_DIG-1:0]   src_blink,
  output logic [N_DIG*7-1:0]       hex,
  output logic [AW-1:0]            active_src,
  output logic                     showing,
  output logic                     conflict
);
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  state_t state, nxt_state;
  logic [N_DIG*4-1:0] pkt, nxt_pkt;
  logic [N_DIG*7-1:0] seg, nxt_hex;
  logic [TW-1:0] tcnt, nxt_tcnt;
  logic [AW-1:0] win;
  logic [N_DIG-1:0] mask;
  logic cap, tmo;
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (src_en[i]) win = AW'(i);
  end
  assign cap = |src_en;
  assign tmo = TIMEOUT_CYC != 0 && state == SHOW && int'(tcnt) == TIMEOUT_CYC - 1;
  assign nxt_state = cap ? SHOW : tmo ? IDLE : state;
  assign nxt_pkt = cap ? src_bcd[int'(win)*N_DIG*4 +: N_DIG*4] : pkt;
  assign nxt_tcnt = (cap || tmo || state == IDLE) ? '0 : &tcnt ? tcnt : tcnt + 1'b1;
  // Decode the next packet so hex updates on the same edge as the capture
  for (genvar d = 0; d < N_DIG; d++) begin : g_dig
    seg7_decode u_dec (.bcd(nxt_pkt[d*4 +: 4]), .seg(seg[d*7 +: 7]));
    assign nxt_hex[d*7 +: 7] = (nxt_state == IDLE || mask[d]) ? SEG_BLANK : seg[d*7 +: 7];
  end
`ifdef DISPLAY_BLINK_EN
  localparam int BW = BLINK_DIV > 2 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt, nxt_bcnt;
  logic [N_DIG-1:0] blk, nxt_blk;
  logic phase, nxt_phase, wrap;
  assign wrap = int'(bcnt) == BLINK_DIV - 1;
  assign nxt_bcnt = (cap || wrap) ? '0 : bcnt + 1'b1;
  assign nxt_phase = cap ? 1'b0 : wrap ? ~phase : phase;
  assign nxt_blk = cap ? src_blink[int'(win)*N_DIG +: N_DIG] : blk;
  assign mask = nxt_phase ? nxt_blk : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      phase <= 1'b0;
      blk <= '0;
    end else begin
      bcnt <= nxt_bcnt;
      phase <= nxt_phase;
      blk <= nxt_blk;
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = ^src_blink;
  assign mask = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pkt <= {N_DIG{BCD_BLANK}};
      tcnt <= '0;
      active_src <= '0;
      conflict <= 1'b0;
      hex <= {N_DIG{SEG_BLANK}};
    end else begin
      state <= nxt_state;
      pkt <= nxt_pkt;
      tcnt <= nxt_tcnt;
      if (cap) active_src <= win;
      conflict <= |(src_en & (src_en - 1'b1));
      hex <= nxt_hex;
    end
  end
  assign showing = state == SHOW;
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: table vectors, corner sequences and a randomized run against a reference model.
module tb_display_mux;
  localparam int TO = 8;
  localparam int BD = 4;
  localparam logic [6:0] P [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [41:0] ALL_BL = {6{7'h7F}};
  logic clk = 1'b0;
  logic rst;
  logic [1:0] src_en;
  logic [47:0] src_bcd;
  logic [11:0] src_blink;
  logic [41:0] hex;
  logic active_src, showing, conflict;
  int checks = 0;
  int failures = 0;
  logic m_show, m_src, m_conf;
  logic [23:0] m_pkt;
  logic [5:0] m_blk;
  int m_idle, m_age;
  typedef struct {
    logic [1:0] en;
    logic [23:0] b0, b1;
    logic [41:0] hex;
    logic as, sh, cf;
  } vec_t;
  vec_t vt [8];

  display_mux #(.N_SRC(2), .N_DIG(6), .TIMEOUT_CYC(TO), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .src_en(src_en), .src_bcd(src_bcd), .src_blink(src_blink),
    .hex(hex), .active_src(active_src), .showing(showing), .conflict(conflict));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: what the panel should show given the most recent capture and its age
  task automatic model_edge();
    if (rst) begin
      m_show = 0; m_src = 0; m_conf = 0; m_pkt = 24'hBBBBBB; m_blk = 0; m_idle = 0; m_age = 0;
    end else if (src_en != 0) begin
      m_src = src_en[0] ? 1'b0 : 1'b1;
      m_pkt = src_bcd[m_src*24 +: 24];
      m_blk = src_blink[m_src*6 +: 6];
      m_conf = $countones(src_en) > 1;
      m_show = 1; m_idle = 0; m_age = 0;
    end else begin
      m_conf = 0;
      m_age++;
      if (m_show) begin
        m_idle++;
        if (m_idle == TO) m_show = 0;
      end
    end
  endtask

  function automatic logic [41:0] model_hex();
    logic [41:0] h;
    for (int d = 0; d < 6; d++) begin
      h[d*7 +: 7] = m_show ? P[m_pkt[d*4 +: 4]] : BL;
`ifdef DISPLAY_BLINK_EN
      if (m_show && m_blk[d] && (m_age / BD) % 2 == 1) h[d*7 +: 7] = BL;
`endif
    end
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    vt[0] = '{2'b01, 24'h654321, 24'h000000, {P[6], P[5], P[4], P[3], P[2], P[1]}, 1'b0, 1'b1, 1'b0};
    vt[1] = '{2'b00, 24'h000000, 24'h000000, {P[6], P[5], P[4], P[3], P[2], P[1]}, 1'b0, 1'b1, 1'b0};
    vt[2] = '{2'b11, 24'hAAAAAA, 24'h000000, {6{7'b0111111}}, 1'b0, 1'b1, 1'b1};
    vt[3] = '{2'b00, 24'h123456, 24'h123456, {6{7'b0111111}}, 1'b0, 1'b1, 1'b0};
    vt[4] = '{2'b10, 24'h111111, 24'h999999, {6{P[9]}}, 1'b1, 1'b1, 1'b0};
    vt[5] = '{2'b10, 24'h222222, 24'hFEDCBA, {BL, BL, BL, BL, BL, P[10]}, 1'b1, 1'b1, 1'b0};
    vt[6] = '{2'b11, 24'h000780, 24'h555555, {P[0], P[0], P[0], P[7], P[8], P[0]}, 1'b0, 1'b1, 1'b1};
    vt[7] = '{2'b00, 24'h999999, 24'h999999, {P[0], P[0], P[0], P[7], P[8], P[0]}, 1'b0, 1'b1, 1'b0};
    rst = 1; src_en = 0; src_bcd = 0; src_blink = 0;
    tick(); tick();
    check("rst_hex", 64'(hex), 64'(ALL_BL));
    check("rst_showing", 64'(showing), 64'd0);
    check("rst_active", 64'(active_src), 64'd0);
    check("rst_conflict", 64'(conflict), 64'd0);
    rst = 0;
    tick();
    check("idle_hex", 64'(hex), 64'(ALL_BL));
    for (int i = 0; i < 8; i++) begin
      src_en = vt[i].en;
      src_bcd = {vt[i].b1, vt[i].b0};
      tick();
      check($sformatf("vec%0d_hex", i), 64'(hex), 64'(vt[i].hex));
      check($sformatf("vec%0d_active", i), 64'(active_src), 64'(vt[i].as));
      check($sformatf("vec%0d_showing", i), 64'(showing), 64'(vt[i].sh));
      check($sformatf("vec%0d_conflict", i), 64'(conflict), 64'(vt[i].cf));
    end
    src_en = 2'b10; src_bcd = {24'h999999, 24'h000000};
    tick();
    src_en = 0;
    for (int i = 0; i < TO; i++) begin
      check($sformatf("to_show%0d", i), 64'(showing), 64'd1);
      tick();
    end
    check("to_idle_showing", 64'(showing), 64'd0);
    check("to_idle_hex", 64'(hex), 64'(ALL_BL));
    src_en = 2'b10;
    tick();
    src_en = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_pre_edge", 64'(showing), 64'd1);
    src_en = 2'b01; src_bcd = {24'h000000, 24'h333333};
    tick();
    src_en = 0;
    check("to_race_showing", 64'(showing), 64'd1);
    check("to_race_hex", 64'(hex), 64'({6{P[3]}}));
    rst = 1; src_en = 2'b10; src_bcd = {24'h444444, 24'h000000};
    tick();
    rst = 0; src_en = 0;
    check("rst_cap_hex", 64'(hex), 64'(ALL_BL));
    check("rst_cap_showing", 64'(showing), 64'd0);
    check("rst_cap_active", 64'(active_src), 64'd0);
    check("rst_cap_conflict", 64'(conflict), 64'd0);
`ifdef DISPLAY_BLINK_EN
    src_en = 2'b01; src_bcd = {24'h000000, 24'h888887}; src_blink = 12'b000000_000001;
    tick();
    src_en = 0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("blink%0d", c), 64'(hex), 64'({{5{P[8]}}, ((c / 4) % 2 == 1) ? BL : P[7]}));
      if (c < 5) tick();
    end
    src_en = 2'b01;
    tick();
    src_en = 0;
    check("blink_restart", 64'(hex), 64'({{5{P[8]}}, P[7]}));
    src_blink = 0;
`endif
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 59) == 0;
      src_en = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
      src_bcd = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      src_blink = 12'($urandom);
      tick();
      check("rnd_hex", 64'(hex), 64'(model_hex()));
      check("rnd_active", 64'(active_src), 64'(m_src));
      check("rnd_showing", 64'(showing), 64'(m_show));
      check("rnd_conflict", 64'(conflict), 64'(m_conf));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_mux.md
# display_mux

Parametrised multi-source 7-segment display controller that drives the N_DIG HEX digits of the lock panel from N_SRC producer FSMs (operacional, setup, and future ones).
- Each source presents a BCD packet with an enable. The block captures the winning packet, remembers which source last wrote, and shows it until another source writes or an idle timeout blanks the panel.
- Outputs are registered active-low segment codes, segment a = LSB.

## Interface
Parameters:
- N_SRC, 2: number of producer sources (≥1).
- N_DIG, 6: number of digits (≥1).
- TIMEOUT_CYC, 0: idle cycles in SHOW before blanking; 0 = never time out.
- BLINK_DIV, 25_000_000: half-period of blink, in clk cycles (≥2; used only with DISPLAY_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- src_en  in  N_SRC  per-source capture request; bit i = source i.
- src_bcd  in  N_SRC×N_DIG×4  per-source digit codes; digit 0 drives hex[0].
- src_blink  in  N_SRC×N_DIG  per-digit blink request (DISPLAY_BLINK_EN only).
- hex  out  N_DIG×7  active-low segment patterns.
- active_src  out  $clog2(N_SRC) (min 1)  index of the source currently shown.
- showing  out  1  1 in SHOW, 0 in IDLE.
- conflict  out  1  one-cycle pulse: more than one src_en bit was set on the previous edge.

## Operation
- FSM states IDLE, SHOW. Reset → IDLE.
- IDLE: hex all 7'h7F, showing=0. Any src_en bit set → capture, go SHOW.
- SHOW: any src_en bit set → capture, stay SHOW, clear timeout counter. No src_en, TIMEOUT_CYC≠0, and counter == TIMEOUT_CYC-1 → IDLE. Otherwise counter increments.
- Capture: winner = lowest set index of src_en. Latch src_bcd[winner] (and src_blink[winner]); active_src ← winner.
- Simultaneous enables: lowest index wins; conflict=1 for one cycle. A single enable gives conflict=0.
- Decode per digit:
  - 0–9 → standard active-low pattern (0=7'b1000000 … 9=7'b0010000).
  - 4'hA → dash 7'b0111111.
  - 4'hB and 4'hC–4'hF → blank 7'b1111111.
- Non-winning sources' packets are discarded. There is no per-source storage.
- Timeout counter width: $clog2(TIMEOUT_CYC+1); saturates, never wraps.

## Timing
- Reset values:
  - hex = all 7'h7F.
  - active_src = 0.
  - showing = 0.
  - conflict = 0.
  - timeout counter = 0.
  - blink counter/phase = 0.
  - latched packet = all 4'hB.
- Latency: src_en sampled high at edge k → hex/active_src/showing reflect the new packet immediately after edge k (1 cycle). conflict asserted after edge k, cleared after edge k+1 unless repeated.
- Continuous src_en held high re-captures every cycle. Display tracks live input with 1-cycle lag; timeout never fires.
- Timeout: last capture at edge k → IDLE after edge k+TIMEOUT_CYC.
- A src_en arriving on the same edge as the timeout wins: stays SHOW.
- rst high at any edge overrides capture and timeout. Reset values apply after that edge.

## Configuration
- Macro DISPLAY_BLINK_EN.
- Defined: src_blink is latched with the packet. The blink counter counts 0..BLINK_DIV-1 and toggles phase on wrap. While phase=1 in SHOW, digits with a latched blink bit output 7'h7F. Counter and phase clear on every capture, so each new packet starts visible.
- Undefined: src_blink is ignored and no blink counter exists. Output equals the non-blink behaviour above.

## Structure
- display_pkg:
  - BCD_DASH=4'hA, BCD_BLANK=4'hB.
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111.
  - typedef state_t {IDLE, SHOW}.
  - Existing bcdPac_t stays for 6-digit producers. Producers with N_SRC=2, N_DIG=6 map into src_bcd.
- One sub-module: seg7_decode, a pure combinational 4-bit → 7-bit decoder. Instantiate N_DIG copies; outputs are registered in display_mux.

## Test plan
- Reset with rst high 2 cycles → hex all 7'h7F, showing=0, active_src=0, conflict=0.
- src_en=2'b01, src0 digits 1,2,3,4,5,6 for one cycle → next cycle hex[0..5]=7'b1111001, 0100100, 0110000, 0011001, 0010010, 0000010; active_src=0; persists after src_en drops.
- src_en=2'b11, src0 all 4'hA, src1 all 4'h0 → hex all 7'b0111111, active_src=0, conflict=1 for exactly one cycle.
- TIMEOUT_CYC=8: capture src1 digits 9, then idle → showing=1 for 8 cycles, then hex all 7'h7F and showing=0. Repeat with a src_en on the 8th cycle → stays SHOW.
- rst asserted mid-SHOW coincident with src_en → after the edge all outputs are at reset values; the capture is lost.
- DISPLAY_BLINK_EN, BLINK_DIV=4, src_blink=6'b000001, digit0=7 → hex[0] alternates 7'b1111000 / 7'h7F every 4 cycles; other digits steady. Re-capture restarts the visible phase.
